// File: rtl/msft_clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package msft_clk_div_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DIV_W_DEF = 16;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Number of high cycles in a period of d cycles: ceil(d/2), evaluated wide to avoid overflow.
    function automatic logic [32:0] half_ceil(input logic [32:0] d);
        return (d + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/msft_clk_div_gen_ch.sv
// One divider channel: period counter, shadowed divisor with valid/ack capture,
// period-aligned gating and sticky illegal-divisor flag.
module msft_clk_div_gen_ch
    import msft_clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_vld_i,
    output logic             div_ack_o,
    input  logic             en_i,
    output logic             clk_o,
    output logic             ctl_clk_o,
    output logic             tick_o,
    output logic             cfg_err_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             full_q, full_d;
    logic             en_q, en_d;
    logic             clk_q, clk_d;
    logic             ctl_q, ctl_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic [DIV_W:0]   cnt_w, div_w, half_w;
    logic             bnd;

    // Extra bit keeps D = 2^DIV_W-1 (and D-1, ceil(D/2)) representable.
    assign cnt_w  = {1'b0, cnt_q};
    assign div_w  = {1'b0, div_q};
    assign half_w = (DIV_W+1)'(half_ceil(33'(div_q)));
    assign bnd    = (cnt_w == div_w - (DIV_W+1)'(1));

    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        div_d  = div_q;
        shd_d  = shd_q;
        full_d = full_q;
        en_d   = en_q;
        ack_d  = 1'b0;
        err_d  = err_q;
        clk_d  = (cnt_w < half_w);
        ctl_d  = clk_d & en_q;
        tick_d = bnd & ~sync_i;

        if (sync_i || bnd) begin
            cnt_d = '0;
            en_d  = en_i;
            if (full_q) begin
                div_d  = shd_q;
                full_d = 1'b0;
            end
        end

        // Capture is gated by the registered flag, so a value arriving on a boundary waits a full period.
        if (div_vld_i && !full_q) begin
            full_d = 1'b1;
            ack_d  = 1'b1;
            if (div_i < DIV_W'(MIN_DIV)) begin
                shd_d = DIV_W'(MIN_DIV);
                err_d = 1'b1;
            end else begin
                shd_d = div_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(DEF_DIV);
            shd_q  <= '0;
            full_q <= 1'b0;
            en_q   <= 1'b0;
            clk_q  <= 1'b0;
            ctl_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            full_q <= full_d;
            en_q   <= en_d;
            clk_q  <= clk_d;
            ctl_q  <= ctl_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign div_ack_o = ack_q;
    assign clk_o     = clk_q;
    assign ctl_clk_o = ctl_q;
    assign tick_o    = tick_q;
    assign cfg_err_o = err_q;

endmodule

// File: rtl/msft_clk_div_gen.sv
// Multi-channel divided-clock / tick generator; sync_i restarts every channel in phase.
module msft_clk_div_gen
    import msft_clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sync_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_vld_i,
    output logic [NUM_CH-1:0]       div_ack_o,
    input  logic [NUM_CH-1:0]       en_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       ctl_clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       cfg_err_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        msft_clk_div_gen_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .sync_i    (sync_i),
            .div_i     (div_i[c*DIV_W +: DIV_W]),
            .div_vld_i (div_vld_i[c]),
            .div_ack_o (div_ack_o[c]),
            .en_i      (en_i[c]),
            .clk_o     (clk_o[c]),
            .ctl_clk_o (ctl_clk_o[c]),
            .tick_o    (tick_o[c]),
            .cfg_err_o (cfg_err_o[c])
        );
    end

endmodule

// File: tb/tb_msft_clk_div_gen.sv
// Randomized bench for msft_clk_div_gen against a per-channel period/position model.
module tb_msft_clk_div_gen;
    import msft_clk_div_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 4;
    localparam int NCYC    = 6000;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    sync_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic [NUM_CH-1:0]       div_vld_i;
    logic [NUM_CH-1:0]       div_ack_o;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       ctl_clk_o;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       cfg_err_o;

    msft_clk_div_gen #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sync_i    (sync_i),
        .div_i     (div_i),
        .div_vld_i (div_vld_i),
        .div_ack_o (div_ack_o),
        .en_i      (en_i),
        .clk_o     (clk_o),
        .ctl_clk_o (ctl_clk_o),
        .tick_o    (tick_o),
        .cfg_err_o (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Model: where each channel sits in its period, the active and pending periods, the latched enable.
    int          m_pos  [NUM_CH];
    int          m_per  [NUM_CH];
    int          m_pend [NUM_CH];
    bit          m_has  [NUM_CH];
    bit          m_en   [NUM_CH];
    bit          m_err  [NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_ctl, e_tick, e_ack, e_err;
    div_t        req    [NUM_CH];

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i) begin
                m_pos[c] = 0; m_per[c] = DEF_DIV; m_has[c] = 0; m_en[c] = 0; m_err[c] = 0;
                e_clk[c] = 0; e_ctl[c] = 0; e_tick[c] = 0; e_ack[c] = 0; e_err[c] = 0;
            end else begin
                bit last, take;
                int v;
                last      = (m_pos[c] == m_per[c] - 1);
                take      = div_vld_i[c] && !m_has[c];
                e_clk[c]  = (m_pos[c] < (m_per[c] + 1) / 2);
                e_ctl[c]  = e_clk[c] && m_en[c];
                e_tick[c] = last && !sync_i;
                e_ack[c]  = take;
                v = int'(div_i[c*DIV_W +: DIV_W]);
                if (take && v < 2) m_err[c] = 1;
                e_err[c] = m_err[c];
                if (sync_i || last) begin
                    m_pos[c] = 0;
                    m_en[c]  = en_i[c];
                    if (m_has[c]) begin
                        m_per[c] = m_pend[c];
                        m_has[c] = 0;
                    end
                end else begin
                    m_pos[c]++;
                end
                if (take) begin
                    m_pend[c] = (v < 2) ? 2 : v;
                    m_has[c]  = 1;
                end
            end
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        sync_i    = 1'b0;
        div_i     = '0;
        div_vld_i = '0;
        en_i      = '1;
        for (int c = 0; c < NUM_CH; c++) req[c] = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            model_step();
            @(posedge clk_i);
            #1;
            check_eq("clk_o",     32'(clk_o),     32'(e_clk));
            check_eq("ctl_clk_o", 32'(ctl_clk_o), 32'(e_ctl));
            check_eq("tick_o",    32'(tick_o),    32'(e_tick));
            check_eq("div_ack_o", 32'(div_ack_o), 32'(e_ack));
            check_eq("cfg_err_o", 32'(cfg_err_o), 32'(e_err));

            // Next inputs: a short reset at start and occasionally later, rare syncs, held requests.
            if (cyc < 3) rst_i = 1'b1;
            else rst_i = ($urandom_range(0, 399) == 0);
            sync_i = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if (div_ack_o[c]) div_vld_i[c] = 1'b0;
                if (!div_vld_i[c] && $urandom_range(0, 14) == 0) begin
                    if ($urandom_range(0, 7) == 0) req[c] = div_t'($urandom_range(0, 1));
                    else req[c] = div_t'($urandom_range(2, 11));
                    div_vld_i[c] = 1'b1;
                end
                div_i[c*DIV_W +: DIV_W] = req[c];
                if ($urandom_range(0, 24) == 0) en_i[c] = ~en_i[c];
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
